// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: per-slot blank/on sequencing, 4-bit PWM dimming and
// frame-synchronous config handoff. Decimal-point support is enabled with SEG7_DP_EN.
module seg7_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int SCAN_DIV   = 100000,
  parameter int BLANK_CYC  = 64
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    upd_valid,
  output logic                    upd_ready,
  input  logic [4*NUM_DIGITS-1:0] upd_digits,
  input  logic [NUM_DIGITS-1:0]   upd_en,
  input  logic [3:0]              upd_bright,
`ifdef SEG7_DP_EN
  input  logic [NUM_DIGITS-1:0]   upd_dp,
`endif
  output logic [NUM_DIGITS-1:0]   an_n,
  output logic [6:0]              seg_n,
  output logic                    dp_n,
  output logic                    frame_tick
);

  localparam int SLOT_W = $clog2(NUM_DIGITS);
  localparam int CNT_W  = $clog2(SCAN_DIV);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_DIGITS - 1);

  typedef enum logic {ST_BLANK, ST_ON} state_t;

  typedef struct packed {
    logic [4*NUM_DIGITS-1:0] dig;
    logic [NUM_DIGITS-1:0]   en;
    logic [3:0]              bright;
`ifdef SEG7_DP_EN
    logic [NUM_DIGITS-1:0]   dp;
`endif
  } cfg_t;

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [3:0]        pwm_q, pwm_d;
  logic              tick_q, tick_d;
  logic [6:0]        seg_q, seg_d;
  logic              pend_full_q, pend_full_d;
  cfg_t              pend_q, pend_d;
  cfg_t              act_q, act_d;
  cfg_t              upd_cfg;
  logic              xfer;
  logic [3:0]        nib;

  function automatic logic [6:0] glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F;
      4'h1: g = 7'h06;
      4'h2: g = 7'h5B;
      4'h3: g = 7'h4F;
      4'h4: g = 7'h66;
      4'h5: g = 7'h6D;
      4'h6: g = 7'h7D;
      4'h7: g = 7'h07;
      4'h8: g = 7'h7F;
      4'h9: g = 7'h6F;
      4'hA: g = 7'h77;
      4'hB: g = 7'h7C;
      4'hC: g = 7'h39;
      4'hD: g = 7'h5E;
      4'hE: g = 7'h79;
      default: g = 7'h71;
    endcase
    return g;
  endfunction

  always_comb begin
    upd_cfg.dig    = upd_digits;
    upd_cfg.en     = upd_en;
    upd_cfg.bright = upd_bright;
`ifdef SEG7_DP_EN
    upd_cfg.dp     = upd_dp;
`endif
  end

  // Slot sequencer: one counter spans the whole slot; state marks the blank/on split.
  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    cnt_d   = cnt_q + CNT_W'(1);
    pwm_d   = pwm_q + 4'd1;
    tick_d  = 1'b0;
    case (state_q)
      ST_BLANK: begin
        pwm_d = 4'd0;
        if (cnt_q == CNT_W'(BLANK_CYC - 1)) state_d = ST_ON;
      end
      ST_ON: begin
        if (cnt_q == CNT_W'(SCAN_DIV - 1)) begin
          state_d = ST_BLANK;
          cnt_d   = '0;
          if (slot_q == LAST_SLOT) begin
            slot_d = '0;
            tick_d = 1'b1;
          end else begin
            slot_d = slot_q + SLOT_W'(1);
          end
        end
      end
      default: state_d = ST_BLANK;
    endcase
  end

  assign upd_ready = !pend_full_q && !ARESET;
  assign xfer      = upd_valid && upd_ready;

  // Active config only moves during the boundary cycle; an empty pending slot lets a
  // transfer in that same cycle go straight to active.
  always_comb begin
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    act_d       = act_q;
    if (tick_q) begin
      if (pend_full_q) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end else if (xfer) begin
        act_d = upd_cfg;
      end
    end else if (xfer) begin
      pend_d      = upd_cfg;
      pend_full_d = 1'b1;
    end
  end

  always_comb begin
    nib = 4'd0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (slot_d == SLOT_W'(k)) nib = act_d.dig[4*k +: 4];
    end
    seg_d = ~glyph(nib);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= ST_BLANK;
      slot_q      <= '0;
      cnt_q       <= '0;
      pwm_q       <= 4'd0;
      tick_q      <= 1'b0;
      seg_q       <= '1;
      pend_full_q <= 1'b0;
      pend_q      <= '0;
      act_q       <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      cnt_q       <= cnt_d;
      pwm_q       <= pwm_d;
      tick_q      <= tick_d;
      seg_q       <= seg_d;
      pend_full_q <= pend_full_d;
      pend_q      <= pend_d;
      act_q       <= act_d;
    end
  end

  always_comb begin
    an_n = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (state_q == ST_ON && slot_q == SLOT_W'(k) && act_q.en[k] && pwm_q <= act_q.bright)
        an_n[k] = 1'b0;
    end
  end

  assign seg_n      = (state_q == ST_ON) ? seg_q : 7'h7F;
  assign frame_tick = tick_q;

`ifdef SEG7_DP_EN
  assign dp_n = ~|(~an_n & act_q.dp);
`else
  assign dp_n = 1'b1;
`endif

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Scoreboard bench for seg7_scan_ctrl: a frame-arithmetic reference model queues expected
// outputs each cycle while stimulus drives directed and random config transfers.
module tb_seg7_scan_ctrl;

  localparam int ND    = 4;
  localparam int SD    = 40;
  localparam int BC    = 4;
  localparam int FRAME = ND * SD;

  typedef struct packed {
    logic [15:0] dig;
    logic [3:0]  en;
    logic [3:0]  br;
    logic [3:0]  dp;
  } cfg_t;

  typedef struct packed {
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       tick;
    logic       pend_full;
  } exp_t;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        upd_valid = 1'b0;
  logic        upd_ready;
  logic [15:0] upd_digits = '0;
  logic [3:0]  upd_en = '0;
  logic [3:0]  upd_bright = '0;
  logic [3:0]  upd_dp = '0;
  logic [3:0]  an_n;
  logic [6:0]  seg_n;
  logic        dp_n;
  logic        frame_tick;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   phase  = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BC)) dut (
    .ACLK       (ACLK),
    .ARESET     (ARESET),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .upd_digits (upd_digits),
    .upd_en     (upd_en),
    .upd_bright (upd_bright),
`ifdef SEG7_DP_EN
    .upd_dp     (upd_dp),
`endif
    .an_n       (an_n),
    .seg_n      (seg_n),
    .dp_n       (dp_n),
    .frame_tick (frame_tick)
  );

  always #5 ACLK = ~ACLK;

  function automatic logic [6:0] ref_glyph(input logic [3:0] n);
    logic [6:0] g;
    case (n)
      4'h0: g = 7'h3F; 4'h1: g = 7'h06; 4'h2: g = 7'h5B; 4'h3: g = 7'h4F;
      4'h4: g = 7'h66; 4'h5: g = 7'h6D; 4'h6: g = 7'h7D; 4'h7: g = 7'h07;
      4'h8: g = 7'h7F; 4'h9: g = 7'h6F; 4'hA: g = 7'h77; 4'hB: g = 7'h7C;
      4'hC: g = 7'h39; 4'hD: g = 7'h5E; 4'hE: g = 7'h79; default: g = 7'h71;
    endcase
    return g;
  endfunction

  // Expected outputs for cycle t after reset release, derived from frame position alone.
  function automatic exp_t expect_at(input int t, input cfg_t c, input bit pf);
    exp_t e;
    int p, slot, off, pwm;
    p    = t % FRAME;
    slot = p / SD;
    off  = p % SD;
    e.an = 4'hF; e.seg = 7'h7F; e.dp = 1'b1;
    e.tick = (t > 0 && p == 0);
    e.pend_full = pf;
    if (off >= BC) begin
      pwm   = (off - BC) % 16;
      e.seg = ~ref_glyph(c.dig[slot*4 +: 4]);
      if (c.en[slot] && pwm <= int'(c.br)) begin
        e.an[slot] = 1'b0;
`ifdef SEG7_DP_EN
        e.dp = !c.dp[slot];
`endif
      end
    end
    return e;
  endfunction

  initial begin : model
    cfg_t act, pend, inc;
    bit   pend_full, started, xfr;
    int   t;
    act = '0; pend = '0; pend_full = 0; started = 0; t = 0;
    forever begin
      @(posedge ACLK); #1;
      inc = {upd_digits, upd_en, upd_bright, upd_dp};
      if (ARESET) begin
        started = 1; t = 0; act = '0; pend_full = 0;
      end else if (started) begin
        xfr = upd_valid && !pend_full;
        if (t > 0 && t % FRAME == 0) begin
          if (pend_full) begin act = pend; pend_full = 0; end
          else if (xfr) act = inc;
        end else if (xfr) begin
          pend = inc; pend_full = 1;
        end
        t++;
      end
      if (started) q.push_back(expect_at(t, act, pend_full));
    end
  end

  initial begin : monitor
    exp_t e;
    logic rdy;
    forever begin
      @(negedge ACLK);
      if (q.size() > 0) begin
        e   = q.pop_front();
        rdy = !e.pend_full && !ARESET;
        checks++;
        if ({an_n, seg_n, dp_n, frame_tick, upd_ready} !== {e.an, e.seg, e.dp, e.tick, rdy}) begin
          errors++;
          $display("FAIL outputs phase%0d @%0t: got an_n=%h seg_n=%h dp_n=%b tick=%b rdy=%b, want an_n=%h seg_n=%h dp_n=%b tick=%b rdy=%b",
                   phase, $time, an_n, seg_n, dp_n, frame_tick, upd_ready,
                   e.an, e.seg, e.dp, e.tick, rdy);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge ACLK);
    #2;
  endtask

  function automatic cfg_t rand_cfg();
    cfg_t c;
    c.dig = 16'($urandom);
    c.en  = 4'($urandom);
    c.br  = 4'($urandom);
    c.dp  = 4'($urandom);
    return c;
  endfunction

  task automatic drive(input cfg_t c);
    upd_digits = c.dig; upd_en = c.en; upd_bright = c.br; upd_dp = c.dp;
  endtask

  task automatic xfer(input cfg_t c);
    bit done = 0;
    drive(c);
    upd_valid = 1'b1;
    for (int i = 0; i < 3 * FRAME; i++) begin
      @(negedge ACLK);
      if (upd_ready) begin done = 1; break; end
    end
    @(posedge ACLK); #2;
    upd_valid = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL xfer_timeout phase%0d: upd_ready=%b, required 1 within %0d cycles", phase, upd_ready, 3 * FRAME);
    end
  endtask

  task automatic wait_tick(input bit need_rdy);
    bit done = 0;
    for (int i = 0; i < 2 * FRAME + 4; i++) begin
      @(negedge ACLK);
      if (frame_tick && (upd_ready || !need_rdy)) begin done = 1; break; end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL tick_timeout phase%0d: frame_tick=%b, required 1 within %0d cycles", phase, frame_tick, 2 * FRAME + 4);
    end
  endtask

  initial begin : stim
    cfg_t c;
    cyc(3);
    ARESET = 1'b0;

    phase = 1;
    xfer('{dig: 16'h1234, en: 4'hF, br: 4'hF, dp: 4'h5});
    cyc(2 * FRAME);

    phase = 2;
    c = rand_cfg(); c.en = 4'h1; c.br = 4'd3;
    xfer(c);
    cyc(2 * FRAME + 17);

    phase = 3;
    xfer(rand_cfg());
    xfer(rand_cfg());
    cyc(2 * FRAME);

    phase = 4;
    wait_tick(1);
    drive('{dig: 16'hABCD, en: 4'hF, br: 4'd9, dp: 4'hA});
    upd_valid = 1'b1;
    @(posedge ACLK); #2;
    upd_valid = 1'b0;
    cyc(FRAME);

    phase = 5;
    wait_tick(0);
    cyc(1);
    xfer(rand_cfg());
    cyc(98);
    ARESET = 1'b1;
    cyc(1);
    ARESET = 1'b0;
    cyc(FRAME + 10);
    c = rand_cfg(); c.en = 4'hF;
    xfer(c);
    cyc(2 * FRAME);

    phase = 6;
    for (int i = 0; i < 8; i++) begin
      cyc($urandom_range(0, 150));
      xfer(rand_cfg());
      if ($urandom_range(0, 1) == 1) xfer(rand_cfg());
    end
    cyc(2 * FRAME);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
